mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, SRAM access cycles per transfer (legal 1..15).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 if_req  in  1  instruction fetch read request, held until if_ready.
REQ-005 if_addr  in  32  fetch byte address.
REQ-006 if_rdata  out  32  fetched instruction word.
REQ-007 if_ready  out  1  one-cycle pulse: fetch complete, if_rdata valid.
REQ-008 mem_read, mem_write  in  1 each  data-stage read/write request, held until mem_ready; never both high.
REQ-009 mem_addr  in  32  data byte address.
REQ-010 mem_wdata  in  32  store data.
REQ-011 mem_rdata  out  32  load data.
REQ-012 mem_ready  out  1  one-cycle pulse: data access complete.
REQ-013 sram_addr  out  30  word address (byte address bits 31:2).
REQ-014 sram_wdata  out  32  write data to SRAM.
REQ-015 sram_rdata  in  32  read data from SRAM.
REQ-016 sram_we_n, sram_oe_n  out  1 each  active-low write/output enables.
REQ-017 busy  out  1  high whenever state is not IDLE.

Function
REQ-018 FSM states IDLE, BUSY, RESP; one shared SRAM port serves both requesters.
REQ-019 IDLE: if mem_read|mem_write then grant DATA; else if if_req then grant INST; else stay IDLE.
REQ-020 Simultaneous data and fetch requests: DATA granted; fetch waits (fixed priority, older instruction first).
REQ-021 On grant: address, write data, direction and grantee latched into registers; transition to BUSY; wait counter loaded with WAIT_CYCLES-1.
REQ-022 BUSY: sram_addr/sram_wdata driven from latched values; sram_oe_n low for reads, sram_we_n low for writes, for every BUSY cycle; counter decrements each cycle.
REQ-023 BUSY with counter 0: read data sampled from sram_rdata into grantee's rdata register; transition to RESP.
REQ-024 RESP: exactly the grantee's ready pulses high for one cycle; SRAM enables high; next state IDLE unconditionally.
REQ-025 Latency: ready asserted WAIT_CYCLES+1 cycles after grant edge; throughput one access per WAIT_CYCLES+2 cycles.
REQ-026 if_rdata/mem_rdata hold last captured value until next completed read of that port; writes do not alter mem_rdata.
REQ-027 Request inputs changing or dropping during BUSY/RESP: ignored; latched access completes, ready still pulses.
REQ-028 Request still high in IDLE after its ready pulse: treated as new request.
REQ-029 sram_addr/sram_wdata in IDLE and RESP: zero; both enables high.
REQ-030 Counter never wraps: WAIT_CYCLES=1 gives exactly one BUSY cycle.

Reset
REQ-031 rst low at a clock edge: state IDLE, counter 0, latches 0, if_rdata=0, mem_rdata=0, both ready 0, busy 0, sram_we_n=sram_oe_n=1, sram_addr=sram_wdata=0.
REQ-032 Reset during BUSY or RESP aborts the access; no ready pulse issued after reset; first post-reset edge with rst high may grant.

Configuration
REQ-033 Macro ARB_ROUND_ROBIN_EN: when defined, a one-bit last-grantee register (reset DATA) gives the opposite port priority on simultaneous requests; when undefined, fixed DATA priority per REQ-020.

Verification
REQ-034 WAIT_CYCLES=2, if_req with if_addr=0x0000_0010, sram_rdata=0xE3A0_1005 -> sram_addr=0x4, sram_oe_n low 2 cycles, if_ready pulse 3 cycles after grant, if_rdata=0xE3A0_1005.
REQ-035 mem_write, mem_addr=0x400, mem_wdata=0xDEAD_BEEF -> sram_addr=0x100, sram_we_n low 2 cycles, sram_wdata=0xDEAD_BEEF, mem_ready pulse, mem_rdata unchanged.
REQ-036 if_req and mem_read raised same cycle -> data served first (mem_ready), fetch granted next IDLE, if_ready 4 cycles after mem_ready; with ARB_ROUND_ROBIN_EN and prior DATA grant, fetch first.
REQ-037 rst low in second BUSY cycle of a read -> next cycle IDLE, enables high, no mem_ready, mem_rdata=0.
REQ-038 mem_read dropped during BUSY -> access completes, mem_ready pulses once, busy returns 0 after RESP.
REQ-039 WAIT_CYCLES=1 back-to-back fetches held high -> if_ready every 3 cycles, no missed or duplicate pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared single-port SRAM arbiter between instruction fetch and data access.
// Optional macro ARB_ROUND_ROBIN_EN alternates priority on simultaneous requests.
module mem_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic [29:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic        r_gnt_data;
    logic [31:0] r_if_rdata;
    logic [31:0] r_mem_rdata;
    logic        w_data_req;
    logic        w_grant;
    logic        w_gnt_data;
    logic        w_pick_data;
    logic        w_in_busy;
    logic        w_unused;

    // Byte offset bits never reach the word-addressed SRAM.
    assign w_unused = ^{if_addr[1:0], mem_addr[1:0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_data <= 1'b1;
        end else if (w_grant) begin
            r_last_data <= w_gnt_data;
        end
    end

    assign w_pick_data = !r_last_data;
`else
    assign w_pick_data = 1'b1;
`endif

    assign w_data_req = mem_read | mem_write;

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_gnt_data = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_grant    = w_data_req | if_req;
                w_gnt_data = (w_data_req & if_req) ? w_pick_data : w_data_req;
                if (w_grant) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_gnt_data  <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_cnt      <= CNT_LOAD;
                r_gnt_data <= w_gnt_data;
                r_addr     <= w_gnt_data ? mem_addr[31:2] : if_addr[31:2];
                r_wdata    <= w_gnt_data ? mem_wdata : 32'd0;
                r_we       <= w_gnt_data & mem_write;
            end else if (r_state == BUSY) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else if (!r_we) begin
                    if (r_gnt_data) begin
                        r_mem_rdata <= sram_rdata;
                    end else begin
                        r_if_rdata <= sram_rdata;
                    end
                end
            end
        end
    end

    assign w_in_busy  = (r_state == BUSY);
    assign sram_addr  = w_in_busy ? r_addr : 30'd0;
    assign sram_wdata = w_in_busy ? r_wdata : 32'd0;
    assign sram_we_n  = !(w_in_busy & r_we);
    assign sram_oe_n  = !(w_in_busy & !r_we);
    assign busy       = (r_state != IDLE);
    assign if_ready   = (r_state == RESP) & !r_gnt_data;
    assign mem_ready  = (r_state == RESP) & r_gnt_data;
    assign if_rdata   = r_if_rdata;
    assign mem_rdata  = r_mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed-vector bench for mem_arbiter (default fixed-priority build).
// A second instance with WAIT_CYCLES=1 covers back-to-back fetch cadence.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] if_rdata, mem_rdata, sram_wdata;
    logic        if_ready, mem_ready, sram_we_n, sram_oe_n, busy;
    logic [29:0] sram_addr;

    logic [31:0] f_if_rdata, f_mem_rdata, f_sram_wdata;
    logic        f_if_ready, f_mem_ready, f_sram_we_n, f_sram_oe_n, f_busy;
    logic [29:0] f_sram_addr;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
        .busy(busy)
    );

    mem_arbiter #(.WAIT_CYCLES(1)) u_fast (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(f_if_rdata), .if_ready(f_if_ready),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(f_mem_rdata), .mem_ready(f_mem_ready),
        .sram_addr(f_sram_addr), .sram_wdata(f_sram_wdata),
        .sram_rdata(sram_rdata),
        .sram_we_n(f_sram_we_n), .sram_oe_n(f_sram_oe_n),
        .busy(f_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ifq;
        logic [31:0] ia;
        logic        mr;
        logic        mw;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [31:0] sr;
        logic        busy;
        logic        ir;
        logic        mrdy;
        logic        we_n;
        logic        oe_n;
        logic [29:0] sa;
        logic [31:0] sw;
        logic [31:0] ird;
        logic [31:0] mrd;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_read = 1'b0; mem_write = 1'b0;
        mem_addr = '0; mem_wdata = '0; sram_rdata = '0;

        // reset, fetch 0x10
        vq.push_back('{0,0,0,0,0,0,0,0,
                       0,0,0,1,1,0,0,0,0});
        vq.push_back('{1,1,32'h10,0,0,0,0,32'hE3A01005,
                       1,0,0,1,0,30'h4,0,0,0});
        vq.push_back('{1,1,32'h10,0,0,0,0,32'hE3A01005,
                       1,0,0,1,0,30'h4,0,0,0});
        vq.push_back('{1,1,32'h10,0,0,0,0,32'hE3A01005,
                       1,1,0,1,1,0,0,32'hE3A01005,0});
        vq.push_back('{1,0,32'h10,0,0,0,0,32'hE3A01005,
                       0,0,0,1,1,0,0,32'hE3A01005,0});
        // write 0x400
        vq.push_back('{1,0,0,0,1,32'h400,32'hDEADBEEF,0,
                       1,0,0,0,1,30'h100,32'hDEADBEEF,32'hE3A01005,0});
        vq.push_back('{1,0,0,0,1,32'h400,32'hDEADBEEF,0,
                       1,0,0,0,1,30'h100,32'hDEADBEEF,32'hE3A01005,0});
        vq.push_back('{1,0,0,0,1,32'h400,32'hDEADBEEF,0,
                       1,0,1,1,1,0,0,32'hE3A01005,0});
        vq.push_back('{1,0,0,0,0,0,0,0,
                       0,0,0,1,1,0,0,32'hE3A01005,0});
        // simultaneous read + fetch, read dropped while busy
        vq.push_back('{1,1,32'h30,1,0,32'h20,0,32'h11112222,
                       1,0,0,1,0,30'h8,0,32'hE3A01005,0});
        vq.push_back('{1,1,32'h30,0,0,32'h20,0,32'h11112222,
                       1,0,0,1,0,30'h8,0,32'hE3A01005,0});
        vq.push_back('{1,1,32'h30,0,0,32'h20,0,32'h11112222,
                       1,0,1,1,1,0,0,32'hE3A01005,32'h11112222});
        vq.push_back('{1,1,32'h30,0,0,0,0,32'h33334444,
                       0,0,0,1,1,0,0,32'hE3A01005,32'h11112222});
        vq.push_back('{1,1,32'h30,0,0,0,0,32'h33334444,
                       1,0,0,1,0,30'hC,0,32'hE3A01005,32'h11112222});
        vq.push_back('{1,1,32'h30,0,0,0,0,32'h33334444,
                       1,0,0,1,0,30'hC,0,32'hE3A01005,32'h11112222});
        vq.push_back('{1,1,32'h30,0,0,0,0,32'h33334444,
                       1,1,0,1,1,0,0,32'h33334444,32'h11112222});
        vq.push_back('{1,0,0,0,0,0,0,0,
                       0,0,0,1,1,0,0,32'h33334444,32'h11112222});
        // write must not disturb load data
        vq.push_back('{1,0,0,0,1,32'h8,32'h5A5A5A5A,32'h99999999,
                       1,0,0,0,1,30'h2,32'h5A5A5A5A,32'h33334444,32'h11112222});
        vq.push_back('{1,0,0,0,1,32'h8,32'h5A5A5A5A,32'h99999999,
                       1,0,0,0,1,30'h2,32'h5A5A5A5A,32'h33334444,32'h11112222});
        vq.push_back('{1,0,0,0,1,32'h8,32'h5A5A5A5A,32'h99999999,
                       1,0,1,1,1,0,0,32'h33334444,32'h11112222});
        vq.push_back('{1,0,0,0,0,0,0,0,
                       0,0,0,1,1,0,0,32'h33334444,32'h11112222});

        #1;
        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; if_req = vq[i].ifq; if_addr = vq[i].ia;
            mem_read = vq[i].mr; mem_write = vq[i].mw;
            mem_addr = vq[i].ma; mem_wdata = vq[i].wd;
            sram_rdata = vq[i].sr;
            step();
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vq[i].busy));
            chk($sformatf("v%0d.if_ready", i), 32'(if_ready), 32'(vq[i].ir));
            chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(vq[i].mrdy));
            chk($sformatf("v%0d.we_n", i), 32'(sram_we_n), 32'(vq[i].we_n));
            chk($sformatf("v%0d.oe_n", i), 32'(sram_oe_n), 32'(vq[i].oe_n));
            chk($sformatf("v%0d.sram_addr", i), 32'(sram_addr), 32'(vq[i].sa));
            chk($sformatf("v%0d.sram_wdata", i), sram_wdata, vq[i].sw);
            chk($sformatf("v%0d.if_rdata", i), if_rdata, vq[i].ird);
            chk($sformatf("v%0d.mem_rdata", i), mem_rdata, vq[i].mrd);
        end

        // reset in second BUSY cycle of a read aborts it
        mem_read = 1'b1; mem_addr = 32'h40; sram_rdata = 32'hAAAA5555;
        step();
        chk("abort.busy1", 32'(busy), 32'd1);
        chk("abort.oe1", 32'(sram_oe_n), 32'd0);
        step();
        chk("abort.busy2", 32'(busy), 32'd1);
        rst = 1'b0;
        step();
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort.we_n", 32'(sram_we_n), 32'd1);
        chk("abort.mem_ready", 32'(mem_ready), 32'd0);
        chk("abort.mem_rdata", mem_rdata, 32'd0);
        chk("abort.if_rdata", if_rdata, 32'd0);
        rst = 1'b1; mem_read = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abort.post%0d.mem_ready", k), 32'(mem_ready), 32'd0);
            chk($sformatf("abort.post%0d.busy", k), 32'(busy), 32'd0);
        end

        // WAIT_CYCLES=1: held fetch completes every third cycle
        rst = 1'b0;
        step();
        rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
        sram_rdata = 32'h0BADF00D;
        for (int k = 1; k <= 12; k++) begin
            step();
            chk($sformatf("fast.k%0d.if_ready", k), 32'(f_if_ready),
                32'((k % 3) == 2));
            chk($sformatf("fast.k%0d.busy", k), 32'(f_busy),
                32'((k % 3) != 0));
        end
        chk("fast.if_rdata", f_if_rdata, 32'h0BADF00D);
        chk("fast.sram_addr_idle", 32'(f_sram_addr), 32'd0);
        if_req = 1'b0;
        step();
        step();
        chk("fast.final_busy", 32'(f_busy), 32'd0);
        chk("fast.final_ready", 32'(f_if_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
